fetch_redirect_ctrl: RTL and testbench

- Control block that sequences the IF-stage PC register.
- Arbitrates PC redirect requests from three pipeline sources: jump (ID), branch mispredict (EX) and trap (WB).
- Drives new_pc/pc_override into the fetch PC register and generates per-stage flush and hold signals.
- Holds fetch for a fixed boot window after reset. Buffers branch/jump redirects that arrive while the pipeline is stalled, so none are lost.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/redirect_select.sv | 36 +++
 rtl/fetch_redirect_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_fetch_redirect_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF-stage redirect controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    KIND_NONE   = 2'd0,
    KIND_JUMP   = 2'd1,
    KIND_BRANCH = 2'd2,
    KIND_TRAP   = 2'd3
  } redirect_kind_e;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HELD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h4000_0000;

  // Fetch addresses are word aligned; the two low bits are always cleared.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/redirect_select.sv
// Combinational redirect arbiter: trap > pending > branch > jump.
module redirect_select
  import fetch_pkg::*;
(
  input  logic           jump_valid,
  input  logic [31:0]    jump_target,
  input  logic           br_mispredict,
  input  logic [31:0]    br_target,
  input  logic           trap_valid,
  input  logic [31:0]    trap_vector,
  input  redirect_kind_e pend_kind,
  input  logic [31:0]    pend_target,
  output redirect_kind_e sel_kind,
  output logic [31:0]    sel_target
);

  // A buffered redirect is older than anything live in ID/EX, so it outranks them.
  always_comb begin
    sel_kind   = KIND_NONE;
    sel_target = '0;
    if (trap_valid) begin
      sel_kind   = KIND_TRAP;
      sel_target = trap_vector;
    end else if (pend_kind != KIND_NONE) begin
      sel_kind   = pend_kind;
      sel_target = pend_target;
    end else if (br_mispredict) begin
      sel_kind   = KIND_BRANCH;
      sel_target = br_target;
    end else if (jump_valid) begin
      sel_kind   = KIND_JUMP;
      sel_target = jump_target;
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// IF-stage PC sequencing: boot hold, redirect arbitration, stall buffering.
// Optional counters enabled by FETCH_REDIRECT_STATS_EN.
module fetch_redirect_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int          BOOT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jump_valid,
  input  logic [31:0] jump_target,
  input  logic        br_mispredict,
  input  logic [31:0] br_target,
  input  logic        trap_valid,
  input  logic [31:0] trap_vector,
  output logic [31:0] new_pc,
  output logic        pc_override,
  output logic        pc_hold,
  output logic        flush_if,
  output logic        flush_id,
  output logic        flush_ex,
  output logic        pending_valid
`ifdef FETCH_REDIRECT_STATS_EN
  ,
  output logic [31:0] redirect_count,
  output logic [15:0] dropped_count
`endif
);

  fetch_state_e   state_q, state_d;
  logic [7:0]     boot_cnt_q, boot_cnt_d;
  redirect_kind_e pend_kind_q, pend_kind_d;
  logic [31:0]    pend_tgt_q, pend_tgt_d;
  redirect_kind_e sel_kind;
  logic [31:0]    sel_target;
  logic           apply;
  logic           hold;
  logic [1:0]     drops;

  redirect_select u_select (
    .jump_valid    (jump_valid),
    .jump_target   (jump_target),
    .br_mispredict (br_mispredict),
    .br_target     (br_target),
    .trap_valid    (trap_valid),
    .trap_vector   (trap_vector),
    .pend_kind     (pend_kind_q),
    .pend_target   (pend_tgt_q),
    .sel_kind      (sel_kind),
    .sel_target    (sel_target)
  );

  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    pend_kind_d = pend_kind_q;
    pend_tgt_d  = pend_tgt_q;
    apply       = 1'b0;
    hold        = 1'b0;
    drops       = 2'd0;
    case (state_q)
      ST_BOOT: begin
        hold       = 1'b1;
        boot_cnt_d = boot_cnt_q + 8'd1;
        if (boot_cnt_q == 8'(BOOT_CYCLES - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (sel_kind == KIND_TRAP) begin
          apply = 1'b1;
          drops = 2'(br_mispredict) + 2'(jump_valid);
        end else if (sel_kind != KIND_NONE) begin
          drops = 2'(br_mispredict & jump_valid);
          if (stall) begin
            hold        = 1'b1;
            pend_kind_d = sel_kind;
            pend_tgt_d  = sel_target;
            state_d     = ST_HELD;
          end else begin
            apply = 1'b1;
          end
        end else begin
          hold = stall;
        end
      end
      ST_HELD: begin
        if (trap_valid) begin
          apply       = 1'b1;
          pend_kind_d = KIND_NONE;
          state_d     = ST_RUN;
          drops       = 2'd1 + 2'(br_mispredict) + 2'(jump_valid);
        end else if (stall) begin
          hold = 1'b1;
          // A pending branch is older than any later jump, so only a branch may replace it.
          if (br_mispredict) begin
            pend_kind_d = KIND_BRANCH;
            pend_tgt_d  = br_target;
            drops       = 2'd1 + 2'(jump_valid);
          end else if (jump_valid) begin
            drops = 2'd1;
            if (pend_kind_q != KIND_BRANCH) begin
              pend_kind_d = KIND_JUMP;
              pend_tgt_d  = jump_target;
            end
          end
        end else begin
          apply       = 1'b1;
          pend_kind_d = KIND_NONE;
          state_d     = ST_RUN;
          drops       = 2'(br_mispredict) + 2'(jump_valid);
        end
      end
      default: begin
        state_d     = ST_BOOT;
        boot_cnt_d  = '0;
        pend_kind_d = KIND_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_BOOT;
      boot_cnt_q  <= '0;
      pend_kind_q <= KIND_NONE;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      pend_kind_q <= pend_kind_d;
    end
  end

  // Target is only meaningful while pend_kind_q != KIND_NONE.
  always_ff @(posedge clk) begin
    pend_tgt_q <= pend_tgt_d;
  end

  // Outputs are forced to their idle values while reset is low so a pending redirect never leaks.
  always_comb begin
    new_pc        = align_pc(RESET_PC);
    pc_override   = 1'b0;
    pc_hold       = 1'b1;
    flush_if      = 1'b0;
    flush_id      = 1'b0;
    flush_ex      = 1'b0;
    pending_valid = 1'b0;
    if (rst) begin
      pc_hold       = hold;
      pending_valid = (state_q == ST_HELD);
      if (apply) begin
        pc_override = 1'b1;
        pc_hold     = 1'b0;
        new_pc      = align_pc(sel_target);
        flush_if    = 1'b1;
        flush_id    = (sel_kind == KIND_BRANCH) || (sel_kind == KIND_TRAP);
        flush_ex    = (sel_kind == KIND_TRAP);
      end
    end
  end

`ifdef FETCH_REDIRECT_STATS_EN
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'd0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      redirect_count <= '0;
      dropped_count  <= '0;
    end else begin
      if (pc_override) redirect_count <= redirect_count + 32'd1;
      dropped_count <= sat_add16(dropped_count, drops);
    end
  end
`else
  logic unused_drops;
  assign unused_drops = ^drops;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed vector table plus randomized run against a reference model.
module tb_fetch_redirect_ctrl;

  localparam logic [31:0] RPC   = 32'h4000_0000;
  localparam int          BOOTN = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic        ovr;
    logic        hold;
    logic [2:0]  fl;   // {flush_if, flush_id, flush_ex}
    logic        pv;
  } out_t;

  typedef struct packed {
    logic        rst;
    logic        stall;
    logic        jv;
    logic [31:0] jt;
    logic        br;
    logic [31:0] bt;
    logic        tv;
    logic [31:0] tt;
    out_t        exp;
  } vec_t;

  logic        clk;
  logic        rst, stall, jump_valid, br_mispredict, trap_valid;
  logic [31:0] jump_target, br_target, trap_vector;
  logic [31:0] new_pc;
  logic        pc_override, pc_hold, flush_if, flush_id, flush_ex, pending_valid;
`ifdef FETCH_REDIRECT_STATS_EN
  logic [31:0] redirect_count;
  logic [15:0] dropped_count;
`endif

  int checks = 0;
  int errors = 0;

  fetch_redirect_ctrl #(.RESET_PC(RPC), .BOOT_CYCLES(BOOTN)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .jump_valid    (jump_valid),
    .jump_target   (jump_target),
    .br_mispredict (br_mispredict),
    .br_target     (br_target),
    .trap_valid    (trap_valid),
    .trap_vector   (trap_vector),
    .new_pc        (new_pc),
    .pc_override   (pc_override),
    .pc_hold       (pc_hold),
    .flush_if      (flush_if),
    .flush_id      (flush_id),
    .flush_ex      (flush_ex),
    .pending_valid (pending_valid)
`ifdef FETCH_REDIRECT_STATS_EN
    ,
    .redirect_count(redirect_count),
    .dropped_count (dropped_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t o(input logic [31:0] pc, input logic ovr, input logic hold,
                             input logic [2:0] fl, input logic pv);
    out_t r;
    r.pc = pc; r.ovr = ovr; r.hold = hold; r.fl = fl; r.pv = pv;
    return r;
  endfunction

  function automatic vec_t v(input logic r, input logic s, input logic j, input logic [31:0] jt,
                             input logic b, input logic [31:0] bt, input logic t,
                             input logic [31:0] tt, input out_t e);
    vec_t x;
    x.rst = r; x.stall = s; x.jv = j; x.jt = jt; x.br = b; x.bt = bt;
    x.tv = t; x.tt = tt; x.exp = e;
    return x;
  endfunction

  function automatic out_t sample();
    return o(new_pc, pc_override, pc_hold, {flush_if, flush_id, flush_ex}, pending_valid);
  endfunction

  task automatic check(input string name, input int idx, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got pc=%h ovr=%b hold=%b fl=%b pv=%b, required pc=%h ovr=%b hold=%b fl=%b pv=%b",
               name, idx, act.pc, act.ovr, act.hold, act.fl, act.pv,
               exp.pc, exp.ovr, exp.hold, exp.fl, exp.pv);
    end
  endtask

  task automatic drive(input vec_t x);
    rst = x.rst; stall = x.stall;
    jump_valid = x.jv; jump_target = x.jt;
    br_mispredict = x.br; br_target = x.bt;
    trap_valid = x.tv; trap_vector = x.tt;
  endtask

  // Reference model: cycles of boot left, plus an optional buffered redirect.
  int          m_boot_left = 0;
  bit          m_pend = 1'b0;
  bit          m_pend_br = 1'b0;
  logic [31:0] m_pend_tgt = '0;

  function automatic out_t redirect_to(input logic [31:0] tgt, input int level, input logic pv);
    return o(tgt & 32'hFFFF_FFFC, 1'b1, 1'b0,
             {1'b1, level >= 2 ? 1'b1 : 1'b0, level >= 3 ? 1'b1 : 1'b0}, pv);
  endfunction

  task automatic model_step(output out_t e);
    e = o(RPC, 1'b0, 1'b1, 3'b000, 1'b0);
    if (!rst) begin
      m_boot_left = BOOTN;
      m_pend      = 1'b0;
    end else if (m_boot_left > 0) begin
      m_boot_left--;
    end else if (trap_valid) begin
      e      = redirect_to(trap_vector, 3, m_pend);
      m_pend = 1'b0;
    end else if (m_pend) begin
      e.pv = 1'b1;
      if (stall) begin
        if (br_mispredict) begin
          m_pend_br  = 1'b1;
          m_pend_tgt = br_target;
        end else if (jump_valid && !m_pend_br) begin
          m_pend_tgt = jump_target;
        end
      end else begin
        e      = redirect_to(m_pend_tgt, m_pend_br ? 2 : 1, 1'b1);
        m_pend = 1'b0;
      end
    end else if (br_mispredict || jump_valid) begin
      if (stall) begin
        m_pend     = 1'b1;
        m_pend_br  = br_mispredict;
        m_pend_tgt = br_mispredict ? br_target : jump_target;
      end else begin
        e = redirect_to(br_mispredict ? br_target : jump_target, br_mispredict ? 2 : 1, 1'b0);
      end
    end else begin
      e.hold = stall;
    end
  endtask

  vec_t tbl[$];

  initial begin
    out_t idle, boot, stl, held;
    vec_t x;
    out_t exp;
    logic s;
    idle = o(RPC, 1'b0, 1'b0, 3'b000, 1'b0);
    boot = o(RPC, 1'b0, 1'b1, 3'b000, 1'b0);
    stl  = o(RPC, 1'b0, 1'b1, 3'b000, 1'b0);
    held = o(RPC, 1'b0, 1'b1, 3'b000, 1'b1);

    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, boot));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, boot));
    for (int i = 0; i < BOOTN; i++) tbl.push_back(v(1, 0, 1, 32'h4000_0F00, 1, 32'h4000_0E00, 0, 0, boot));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, idle));
    tbl.push_back(v(1, 0, 1, 32'h4000_0200, 1, 32'h4000_0100, 0, 0, o(32'h4000_0100, 1, 0, 3'b110, 0)));
    tbl.push_back(v(1, 1, 1, 32'h4000_0040, 0, 0, 0, 0, stl));
    for (int i = 0; i < 3; i++) tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, held));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, o(32'h4000_0040, 1, 0, 3'b100, 1)));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, idle));
    tbl.push_back(v(1, 1, 1, 32'h4000_0300, 0, 0, 0, 0, stl));
    tbl.push_back(v(1, 1, 0, 0, 1, 32'h4000_0080, 0, 0, held));
    tbl.push_back(v(1, 1, 1, 32'h4000_0400, 0, 0, 0, 0, held));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, o(32'h4000_0080, 1, 0, 3'b110, 1)));
    tbl.push_back(v(1, 1, 0, 0, 1, 32'h4000_0500, 0, 0, stl));
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 1, 32'h4000_0003, o(32'h4000_0000, 1, 0, 3'b111, 1)));
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, stl));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, idle));
    tbl.push_back(v(1, 1, 1, 32'h4000_0600, 0, 0, 0, 0, stl));
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, held));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, boot));
    for (int i = 0; i < BOOTN; i++) tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, boot));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, idle));
    tbl.push_back(v(1, 0, 0, 0, 1, 32'h1234_5678, 1, 32'h4000_0ABE, o(32'h4000_0ABC, 1, 0, 3'b111, 0)));
    tbl.push_back(v(1, 0, 1, 32'h4000_0A03, 0, 0, 0, 0, o(32'h4000_0A00, 1, 0, 3'b100, 0)));

    drive(v(0, 0, 0, 0, 0, 0, 0, 0, boot));
    foreach (tbl[i]) begin
      @(posedge clk); #1;
      drive(tbl[i]);
      @(negedge clk);
      check("vector", i, sample(), tbl[i].exp);
    end

    s = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 3) == 0) s = ~s;
      x.rst   = (n == 0) ? 1'b0 : ($urandom_range(0, 149) != 0);
      x.stall = s;
      x.jv    = ($urandom_range(0, 2) == 0);
      x.jt    = $urandom;
      x.br    = ($urandom_range(0, 3) == 0);
      x.bt    = $urandom;
      x.tv    = ($urandom_range(0, 11) == 0);
      x.tt    = $urandom;
      x.exp   = '0;
      drive(x);
      model_step(exp);
      @(negedge clk);
      check("random", n, sample(), exp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
